qbus_dma_master: RTL and testbench

Q-bus DMA bus-master sequencer that sits directly below a disk controller's DMA request interface (`dma_read_req` / `dma_write_req` / `dma_bus_master` / `dma_complete` / `dma_nxm`). It arbitrates for the bus via DMR/DMG/SACK and runs DATI or DATO cycles on the Q-bus control lines. It tells the device exactly when address and data must be driven and when read data on `RDL` is valid. One instance serves one device; address and data lines are driven by the device, gated by this block's enables.

---
 rtl/qbus_dma_master_pkg.sv | 12 +
 rtl/qbus_sync.sv | 21 ++
 rtl/qbus_dma_master.sv | 156 +++++++++++++++
 tb/tb_qbus_dma_master.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_dma_master_pkg.sv
// Shared state encoding and default sizing for the Q-bus DMA master.
package qbus_dma_master_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ACK, S_ADDR, S_ASYNC, S_DATA, S_TERM, S_NEXT, S_REL
  } state_t;

  localparam int QSIC_DMA_TIMEOUT   = 200;
  localparam int QSIC_DMA_MAX_BURST = 4;
  localparam logic [2:0] BURST_SAT  = 3'd7;

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for one asynchronous Q-bus receiver line.
module qbus_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_dma_master.sv
// Q-bus DMA bus-master sequencer: DMR/DMG/SACK arbitration, then DATI/DATO cycles.
// Define QSIC_DMA_BURST_EN to allow up to MAX_BURST transfers per bus tenure.
module qbus_dma_master
  import qbus_dma_master_pkg::*;
#(
  parameter int TIMEOUT   = QSIC_DMA_TIMEOUT,
  parameter int MAX_BURST = QSIC_DMA_MAX_BURST
) (
  input  logic clk,
  input  logic RINIT,
  input  logic dma_read_req,
  input  logic dma_write_req,
  output logic dma_bus_master,
  output logic dma_complete,
  output logic dma_nxm,
  input  logic RDMGI,
  input  logic RSYNC,
  input  logic RRPLY,
  output logic TDMR,
  output logic TDMGO,
  output logic TSACK,
  output logic TSYNC,
  output logic TDIN,
  output logic TDOUT,
  output logic TWTBT,
  output logic addr_drive,
  output logic data_drive
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
`ifdef QSIC_DMA_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic dmg_s, sync_s, rply_s;

  qbus_sync u_sync_dmg  (.clk(clk), .rst(RINIT), .d(RDMGI), .q(dmg_s));
  qbus_sync u_sync_sync (.clk(clk), .rst(RINIT), .d(RSYNC), .q(sync_s));
  qbus_sync u_sync_rply (.clk(clk), .rst(RINIT), .d(RRPLY), .q(rply_s));

  state_t           state;
  logic             dir_wr;
  logic             addr_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [2:0]       burst_cnt;
  logic             dmgo_en;
  logic             req_dir;

  assign req_dir = dir_wr ? dma_write_req : dma_read_req;
  // Grant is daisy-chained combinationally only while idle; absorbed otherwise.
  assign TDMGO   = dmgo_en & dmg_s;

  always_ff @(posedge clk) begin
    if (RINIT) begin
      state          <= S_IDLE;
      dmgo_en        <= 1'b1;
      dir_wr         <= 1'b0;
      addr_cnt       <= 1'b0;
      tmo_cnt        <= '0;
      burst_cnt      <= '0;
      TDMR           <= 1'b0;
      TSACK          <= 1'b0;
      TSYNC          <= 1'b0;
      TDIN           <= 1'b0;
      TDOUT          <= 1'b0;
      TWTBT          <= 1'b0;
      addr_drive     <= 1'b0;
      data_drive     <= 1'b0;
      dma_bus_master <= 1'b0;
      dma_complete   <= 1'b0;
      dma_nxm        <= 1'b0;
    end else begin
      dma_complete <= 1'b0;
      dma_nxm      <= 1'b0;
      case (state)
        S_IDLE: if (dma_read_req | dma_write_req) begin
          dir_wr  <= dma_write_req;
          TDMR    <= 1'b1;
          dmgo_en <= 1'b0;
          state   <= S_REQ;
        end
        S_REQ: if (dmg_s & ~sync_s & ~rply_s) begin
          TDMR           <= 1'b0;
          TSACK          <= 1'b1;
          dma_bus_master <= 1'b1;
          burst_cnt      <= '0;
          state          <= S_ACK;
        end
        // A request withdrawn during arbitration still gets a clean SACK release.
        S_ACK: if (req_dir) begin
          addr_cnt   <= 1'b0;
          addr_drive <= 1'b1;
          TWTBT      <= dir_wr;
          state      <= S_ADDR;
        end else begin
          state <= S_REL;
        end
        S_ADDR: if (!addr_cnt) begin
          addr_cnt <= 1'b1;
        end else begin
          TSYNC <= 1'b1;
          state <= S_ASYNC;
        end
        S_ASYNC: begin
          addr_drive <= 1'b0;
          TWTBT      <= 1'b0;
          tmo_cnt    <= '0;
          TDIN       <= ~dir_wr;
          data_drive <= dir_wr;
          state      <= S_DATA;
        end
        S_DATA: if (rply_s) begin
          TDIN         <= 1'b0;
          TDOUT        <= 1'b0;
          dma_complete <= 1'b1;
          if (burst_cnt != BURST_SAT) burst_cnt <= burst_cnt + 3'd1;
          state        <= S_TERM;
        end else if (tmo_cnt == TMO_LAST) begin
          TDIN       <= 1'b0;
          TDOUT      <= 1'b0;
          TSYNC      <= 1'b0;
          data_drive <= 1'b0;
          dma_nxm    <= 1'b1;
          state      <= S_REL;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
          TDOUT   <= dir_wr;
        end
        S_TERM: if (!rply_s) begin
          TSYNC      <= 1'b0;
          data_drive <= 1'b0;
          state      <= S_NEXT;
        end
        S_NEXT: if (BURST_EN && req_dir && (int'(burst_cnt) < MAX_BURST)) begin
          addr_cnt   <= 1'b0;
          addr_drive <= 1'b1;
          TWTBT      <= dir_wr;
          state      <= S_ADDR;
        end else begin
          state <= S_REL;
        end
        S_REL: begin
          TSACK          <= 1'b0;
          dma_bus_master <= 1'b0;
          dmgo_en        <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_dma_master.sv
// Directed bench for qbus_dma_master with a simple zero/fixed-wait memory responder.
module tb_qbus_dma_master;

  localparam int TMO = 200;
`ifdef QSIC_DMA_BURST_EN
  localparam int EXP_TENURES = 2;
  localparam int EXP_FIRST   = 4;
`else
  localparam int EXP_TENURES = 6;
  localparam int EXP_FIRST   = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RINIT, dma_read_req, dma_write_req, RDMGI, RSYNC, RRPLY;
  logic dma_bus_master, dma_complete, dma_nxm;
  logic TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT, TWTBT, addr_drive, data_drive;
  logic [11:0] outs;

  assign outs = {TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT, TWTBT,
                 addr_drive, data_drive, dma_bus_master, dma_complete, dma_nxm};

  qbus_dma_master #(.TIMEOUT(TMO), .MAX_BURST(4)) dut (
    .clk(clk), .RINIT(RINIT),
    .dma_read_req(dma_read_req), .dma_write_req(dma_write_req),
    .dma_bus_master(dma_bus_master), .dma_complete(dma_complete), .dma_nxm(dma_nxm),
    .RDMGI(RDMGI), .RSYNC(RSYNC), .RRPLY(RRPLY),
    .TDMR(TDMR), .TDMGO(TDMGO), .TSACK(TSACK), .TSYNC(TSYNC),
    .TDIN(TDIN), .TDOUT(TDOUT), .TWTBT(TWTBT),
    .addr_drive(addr_drive), .data_drive(data_drive)
  );

  int checks = 0;
  int passes = 0;
  int strobe_cnt = 0;
  int mem_wait = 4;
  bit mem_dead = 1'b0;
  bit auto_grant = 1'b0;
  logic [15:0] rdl = 16'h0;
  logic [15:0] got_data = 16'h0;

  // One clock; the device latches RDL on dma_complete before the memory reacts.
  task automatic step();
    @(posedge clk);
    #1;
    if (dma_complete) got_data = rdl;
    if (auto_grant) RDMGI = TDMR & ~TSACK;
    if ((TDIN | TDOUT) && !mem_dead) strobe_cnt++;
    else strobe_cnt = 0;
    RRPLY = (strobe_cnt >= mem_wait);
    rdl = RRPLY ? 16'o123456 : 16'h0000;
  endtask

  task automatic test_reset();
    RINIT = 1'b1;
    repeat (3) step();
    checks++;
    if (outs !== 12'h000) $display("FAIL reset_outs: got %h want 000", outs);
    else passes++;
    RINIT = 1'b0;
    step();
    checks++;
    if (outs !== 12'h000) $display("FAIL idle_outs: got %h want 000", outs);
    else passes++;
  endtask

  task automatic test_grant_passthru();
    RDMGI = 1'b1;
    step();
    checks++;
    if (TDMGO !== 1'b0) $display("FAIL dmgo_early: got %b want 0", TDMGO);
    else passes++;
    step();
    checks++;
    if (TDMGO !== 1'b1) $display("FAIL dmgo_pass: got %b want 1", TDMGO);
    else passes++;
    checks++;
    if ({TDMR, TSACK, TSYNC} !== 3'b000) $display("FAIL pass_quiet: got %b want 000", {TDMR, TSACK, TSYNC});
    else passes++;
    RDMGI = 1'b0;
    repeat (2) step();
    checks++;
    if (TDMGO !== 1'b0) $display("FAIL dmgo_drop: got %b want 0", TDMGO);
    else passes++;
  endtask

  task automatic test_dati();
    int cd;
    int tdmr_after;
    cd = -1;
    tdmr_after = 0;
    RSYNC = 1'b1;
    dma_read_req = 1'b1;
    step();
    checks++;
    if ({TDMR, TDMGO} !== 2'b10) $display("FAIL req_state: got %b want 10", {TDMR, TDMGO});
    else passes++;
    RDMGI = 1'b1;
    repeat (4) step();
    checks++;
    if (TSACK !== 1'b0) $display("FAIL busy_bus: got %b want 0", TSACK);
    else passes++;
    RSYNC = 1'b0;
    repeat (2) step();
    checks++;
    if (TSACK !== 1'b0) $display("FAIL sack_early: got %b want 0", TSACK);
    else passes++;
    step();
    checks++;
    if ({TSACK, dma_bus_master, TDMR, TDMGO} !== 4'b1100)
      $display("FAIL ack_state: got %b want 1100", {TSACK, dma_bus_master, TDMR, TDMGO});
    else passes++;
    RDMGI = 1'b0;
    step();
    checks++;
    if ({addr_drive, TWTBT, TSYNC} !== 3'b100)
      $display("FAIL addr_state: got %b want 100", {addr_drive, TWTBT, TSYNC});
    else passes++;
    repeat (2) step();
    checks++;
    if ({addr_drive, TSYNC, TDIN} !== 3'b110)
      $display("FAIL async_state: got %b want 110", {addr_drive, TSYNC, TDIN});
    else passes++;
    step();
    checks++;
    if ({TDIN, TSYNC, addr_drive} !== 3'b110)
      $display("FAIL data_state: got %b want 110", {TDIN, TSYNC, addr_drive});
    else passes++;
    for (int d = 1; d < 20 && cd < 0; d++) begin
      step();
      if (dma_complete) begin
        cd = d;
        dma_read_req = 1'b0;
        checks++;
        if (TDIN !== 1'b0) $display("FAIL din_at_cmpl: got %b want 0", TDIN);
        else passes++;
      end
    end
    checks++;
    if (cd != 6) $display("FAIL cmpl_latency: got %0d want 6", cd);
    else passes++;
    checks++;
    if (got_data !== 16'o123456) $display("FAIL rdl_data: got %o want 123456", got_data);
    else passes++;
    for (int i = 0; i < 10 && TSACK; i++) step();
    checks++;
    if ({TSACK, dma_bus_master} !== 2'b00) $display("FAIL sack_release: got %b want 00", {TSACK, dma_bus_master});
    else passes++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (TDMR) tdmr_after++;
    end
    checks++;
    if (tdmr_after != 0) $display("FAIL no_rearb: got %0d want 0", tdmr_after);
    else passes++;
  endtask

  task automatic test_dato();
    int dd_first, tdout_first, dd_cnt, twtbt_cnt, twtbt_bad, comp_at, ncomp, din_cnt;
    dd_first = -1; tdout_first = -1; dd_cnt = 0; twtbt_cnt = 0;
    twtbt_bad = 0; comp_at = -1; ncomp = 0; din_cnt = 0;
    auto_grant = 1'b1;
    dma_write_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (TWTBT) begin
        twtbt_cnt++;
        if (!addr_drive) twtbt_bad++;
      end
      if (data_drive) begin
        dd_cnt++;
        if (dd_first < 0) dd_first = i;
      end
      if (TDOUT && tdout_first < 0) tdout_first = i;
      if (TDIN) din_cnt++;
      if (dma_complete) begin
        ncomp++;
        comp_at = i;
        dma_write_req = 1'b0;
      end
    end
    auto_grant = 1'b0;
    RDMGI = 1'b0;
    checks++;
    if (twtbt_cnt != 3 || twtbt_bad != 0)
      $display("FAIL twtbt_window: got %0d/%0d want 3/0", twtbt_cnt, twtbt_bad);
    else passes++;
    checks++;
    if (tdout_first - dd_first != 1) $display("FAIL tdout_deskew: got %0d want 1", tdout_first - dd_first);
    else passes++;
    checks++;
    if (dd_cnt != 10) $display("FAIL dd_hold: got %0d want 10", dd_cnt);
    else passes++;
    checks++;
    if (comp_at - dd_first != 7) $display("FAIL dato_cmpl: got %0d want 7", comp_at - dd_first);
    else passes++;
    checks++;
    if (ncomp != 1 || din_cnt != 0) $display("FAIL dato_count: got %0d/%0d want 1/0", ncomp, din_cnt);
    else passes++;
  endtask

  task automatic test_nxm();
    int din_first, nxm_at, nxm_cnt, ncomp;
    din_first = -1; nxm_at = -1; nxm_cnt = 0; ncomp = 0;
    mem_dead = 1'b1;
    auto_grant = 1'b1;
    dma_read_req = 1'b1;
    for (int i = 0; i < 400 && nxm_at < 0; i++) begin
      step();
      if (TDIN && din_first < 0) din_first = i;
      if (dma_complete) ncomp++;
      if (dma_nxm) begin
        nxm_cnt++;
        nxm_at = i;
        dma_read_req = 1'b0;
        checks++;
        if ({TSYNC, TDIN, TSACK} !== 3'b001) $display("FAIL nxm_rel: got %b want 001", {TSYNC, TDIN, TSACK});
        else passes++;
      end
    end
    step();
    if (dma_nxm) nxm_cnt++;
    checks++;
    if (nxm_at - din_first != TMO) $display("FAIL nxm_time: got %0d want %0d", nxm_at - din_first, TMO);
    else passes++;
    checks++;
    if ({TSACK, dma_bus_master, TSYNC, TDIN} !== 4'b0000)
      $display("FAIL nxm_after: got %b want 0000", {TSACK, dma_bus_master, TSYNC, TDIN});
    else passes++;
    checks++;
    if (nxm_cnt != 1 || ncomp != 0) $display("FAIL nxm_pulse: got %0d/%0d want 1/0", nxm_cnt, ncomp);
    else passes++;
    mem_dead = 1'b0;
    auto_grant = 1'b0;
    RDMGI = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_burst();
    int ncomp, tenures, first, dmr_rises, both, budget;
    bit prev_sack, prev_dmr;
    ncomp = 0; tenures = 0; first = 0; dmr_rises = 0; both = 0; budget = 0;
    prev_sack = 1'b0; prev_dmr = 1'b0;
    auto_grant = 1'b1;
    dma_read_req = 1'b1;
    while (budget < 600 && !(ncomp == 6 && !TSACK && !TDMR)) begin
      step();
      budget++;
      if (TSACK && !prev_sack) tenures++;
      if (TDMR && !prev_dmr) dmr_rises++;
      if (TDMGO && (TDMR || TSACK)) both++;
      if (dma_complete) begin
        ncomp++;
        if (tenures == 1) first++;
        if (ncomp == 6) dma_read_req = 1'b0;
      end
      prev_sack = TSACK;
      prev_dmr = TDMR;
    end
    auto_grant = 1'b0;
    RDMGI = 1'b0;
    checks++;
    if (ncomp != 6) $display("FAIL burst_words: got %0d want 6", ncomp);
    else passes++;
    checks++;
    if (tenures != EXP_TENURES || dmr_rises != EXP_TENURES)
      $display("FAIL burst_tenures: got %0d/%0d want %0d", tenures, dmr_rises, EXP_TENURES);
    else passes++;
    checks++;
    if (first != EXP_FIRST) $display("FAIL burst_first: got %0d want %0d", first, EXP_FIRST);
    else passes++;
    checks++;
    if (both != 0) $display("FAIL dmgo_excl: got %0d want 0", both);
    else passes++;
  endtask

  task automatic test_abort();
    int sack_cnt, addr_cnt, sync_cnt;
    sack_cnt = 0; addr_cnt = 0; sync_cnt = 0;
    dma_read_req = 1'b1;
    step();
    dma_read_req = 1'b0;
    auto_grant = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (TSACK) sack_cnt++;
      if (addr_drive) addr_cnt++;
      if (TSYNC) sync_cnt++;
    end
    auto_grant = 1'b0;
    RDMGI = 1'b0;
    checks++;
    if (sack_cnt != 2) $display("FAIL abort_sack: got %0d want 2", sack_cnt);
    else passes++;
    checks++;
    if (addr_cnt != 0 || sync_cnt != 0) $display("FAIL abort_nocycle: got %0d/%0d want 0/0", addr_cnt, sync_cnt);
    else passes++;
    checks++;
    if ({TDMR, TSACK} !== 2'b00) $display("FAIL abort_idle: got %b want 00", {TDMR, TSACK});
    else passes++;
  endtask

  task automatic test_reset_mid();
    int ncomp, waited;
    ncomp = 0; waited = 0;
    mem_dead = 1'b1;
    auto_grant = 1'b1;
    dma_read_req = 1'b1;
    while (!TDIN && waited < 40) begin
      step();
      waited++;
    end
    checks++;
    if (TDIN !== 1'b1) $display("FAIL rmid_reach: got %b want 1", TDIN);
    else passes++;
    repeat (2) step();
    mem_dead = 1'b0;
    auto_grant = 1'b0;
    RDMGI = 1'b0;
    dma_read_req = 1'b0;
    RINIT = 1'b1;
    step();
    checks++;
    if (outs !== 12'h000) $display("FAIL rmid_outs: got %h want 000", outs);
    else passes++;
    RINIT = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dma_complete || dma_nxm) ncomp++;
    end
    checks++;
    if (ncomp != 0 || outs !== 12'h000) $display("FAIL rmid_after: got %0d/%h want 0/000", ncomp, outs);
    else passes++;
  endtask

  initial begin
    RINIT = 1'b1; dma_read_req = 1'b0; dma_write_req = 1'b0;
    RDMGI = 1'b0; RSYNC = 1'b0; RRPLY = 1'b0;
    test_reset();
    test_grant_passthru();
    test_dati();
    test_dato();
    test_nxm();
    test_burst();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
